prt_dprx_sdp_cap: RTL and testbench
===================================

PRT_DPRX_SDP_CAP -- requirements
Module: prt_dprx_sdp_cap

Interface
REQ-001 The block SHALL have parameter P_MAX_WORDS, default 16, giving the maximum packet length in 32-bit words including the header word; legal range 2..32.
REQ-002 The block SHALL have the following ports:
- RST_IN  in  1  synchronous, active-high reset
- CLK_IN  in  1  the single clock; connects to the SDP clock
- SDP_SOP_IN  in  1  start of packet
- SDP_EOP_IN  in  1  end of packet
- SDP_DAT_IN  in  32  packet word; the first word is the header HB0..HB3, with HB0 at [7:0] and HB1 at [15:8]
- SDP_VLD_IN  in  1  word valid; there is no backpressure
- CFG_EN_IN  in  1  capture enable
- CFG_TYPE_IN  in  8  HB1 type filter; 0 means accept all types
- ACK_IN  in  1  host acknowledge; one-cycle pulse
- RD_ADR_IN  in  5  read word address
- RD_DAT_OUT  out  32  read data
- RD_LEN_OUT  out  6  committed packet length in words
- RD_TYPE_OUT  out  8  committed packet HB1
- NEW_OUT  out  1  a committed packet is pending acknowledgement
- IRQ_OUT  out  1  one-cycle pulse on each commit
- DROP_CNT_OUT  out  8  saturating count of dropped packets
- ERR_CNT_OUT  out  8  saturating count of malformed packets

Function
REQ-003 Input words SHALL be accepted only on cycles where SDP_VLD_IN=1; SOP and EOP SHALL be ignored whenever VLD=0.
REQ-004 The FSM SHALL have three states: IDLE, CAP and DROP; the reset state is IDLE.
REQ-005 IDLE -> CAP SHALL occur on VLD&SOP&CFG_EN when CFG_TYPE_IN is 0 or equals DAT[15:8]; the header is written at word 0 and the word count is set to 1.
REQ-006 IDLE -> DROP SHALL occur on VLD&SOP when the type filter mismatches; filtered packets SHALL NOT increment any counter.
REQ-007 In IDLE, a VLD beat without SOP SHALL be discarded and SHALL increment ERR_CNT.
REQ-008 In CAP, each VLD beat SHALL be written at the current word count, and the count SHALL then increment.
REQ-009 A beat that would exceed P_MAX_WORDS SHALL send the FSM to DROP and increment ERR_CNT; no commit follows.
REQ-010 VLD&EOP in CAP SHALL commit the packet and return the FSM to IDLE; commit length = count including the EOP word.
REQ-011 SOP and EOP on the same beat in IDLE SHALL commit a 1-word packet; the FSM stays in IDLE.
REQ-012 SOP while in CAP SHALL abort the current packet, increment ERR_CNT, and start capture of the new packet per REQ-005/006.
REQ-013 DROP SHALL remain until VLD&EOP, then go to IDLE; SOP in DROP is handled as in REQ-012 but without the ERR_CNT increment.
REQ-014 CFG_EN_IN=0 SHALL force the FSM to IDLE at once with no commit; a partial packet is discarded silently.
REQ-015 Storage SHALL be two banks; capture writes the inactive bank and the host reads the committed bank.
REQ-016 At commit with NEW=0: the bank pointer SHALL toggle, LEN/TYPE SHALL update, NEW SHALL be set, and IRQ_OUT SHALL pulse for one cycle in the next cycle.
REQ-017 At commit with NEW=1: the packet SHALL be discarded, DROP_CNT SHALL increment, and the host view SHALL stay unchanged.
REQ-018 ACK_IN SHALL clear NEW; when ACK and commit coincide, the ACK is applied first and the commit succeeds.
REQ-019 RD_DAT_OUT SHALL have 1-cycle latency from RD_ADR_IN; it returns 0 when RD_ADR_IN >= RD_LEN_OUT or >= P_MAX_WORDS.
REQ-020 Both counters SHALL saturate at 255 and clear only on reset.
REQ-021 Input-to-NEW latency SHALL be 1 cycle: NEW_OUT, RD_LEN_OUT and RD_TYPE_OUT are valid in the cycle after the EOP beat.

Reset
REQ-022 RST_IN SHALL force: FSM=IDLE, bank pointer=0, NEW_OUT=0, IRQ_OUT=0, RD_LEN_OUT=0, RD_TYPE_OUT=0, RD_DAT_OUT=0, DROP_CNT_OUT=0, ERR_CNT_OUT=0.
REQ-023 Reset asserted mid-packet SHALL discard the packet with no commit and no counter update; memory contents need not be cleared.

Structure
REQ-024 The FSM state enum and the header field offsets (HB0 [7:0], HB1 [15:8]) SHALL live in a shared package, prt_dprx_sdp_pkg.
REQ-025 Storage SHALL be a sub-module, prt_dprx_sdp_ram: simple dual-port, 2*P_MAX_WORDS x 32, registered read.
REQ-026 The top level of the block SHALL hold the FSM, the word counter, the bank pointer and the status registers.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- 9-word packet, HB1=0x84, filter 0 -> IRQ pulse; NEW=1, LEN=9, TYPE=0x84; reading words 0..8 returns the data, address 9 returns 0.
- Second packet before ACK -> DROP_CNT=1; LEN/TYPE/data unchanged. ACK then third packet -> commit succeeds.
- Filter 0x87, packet HB1=0x84 -> no IRQ, counters stay 0. Then HB1=0x87 -> commit.
- 17-word packet with P_MAX_WORDS=16 -> ERR_CNT=1, no commit. Next 4-word packet commits with LEN=4.
- SOP mid-packet after 3 words, new 5-word packet -> ERR_CNT=1, LEN=5. Also: SOP+EOP single beat -> LEN=1.
- ACK coincident with EOP of a pending packet -> NEW remains 1, new LEN shown, DROP_CNT unchanged. Reset mid-packet -> all outputs 0.

Source files
------------

// File: rtl/prt_dprx_sdp_pkg.sv
// prt_dprx_sdp_pkg: shared FSM state type and SDP header field offsets.
package prt_dprx_sdp_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_CAP, ST_DROP} state_t;

    localparam int HB_W    = 8;
    localparam int HB0_LSB = 0;
    localparam int HB1_LSB = 8;

    function automatic logic [HB_W-1:0] hdr_hb1(input logic [31:0] w);
        return w[HB1_LSB +: HB_W];
    endfunction

endpackage

// File: rtl/prt_dprx_sdp_ram.sv
// prt_dprx_sdp_ram: simple dual-port 32-bit storage with registered read.
module prt_dprx_sdp_ram #(
    parameter int P_DEPTH = 32,
    parameter int P_AW    = 5
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [P_AW-1:0] wadr_i,
    input  logic [31:0]     wdat_i,
    input  logic [P_AW-1:0] radr_i,
    output logic [31:0]     rdat_o
);

    logic [31:0] mem_q [P_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wadr_i] <= wdat_i;
        rdat_o <= mem_q[radr_i];
    end

endmodule

// File: rtl/prt_dprx_sdp_cap.sv
// prt_dprx_sdp_cap: captures filtered SDP packets into a double-buffered store
// and presents the last committed packet to the host until acknowledged.
module prt_dprx_sdp_cap
    import prt_dprx_sdp_pkg::*;
#(
    parameter int P_MAX_WORDS = 16
) (
    input  logic        RST_IN,
    input  logic        CLK_IN,
    input  logic        SDP_SOP_IN,
    input  logic        SDP_EOP_IN,
    input  logic [31:0] SDP_DAT_IN,
    input  logic        SDP_VLD_IN,
    input  logic        CFG_EN_IN,
    input  logic [7:0]  CFG_TYPE_IN,
    input  logic        ACK_IN,
    input  logic [4:0]  RD_ADR_IN,
    output logic [31:0] RD_DAT_OUT,
    output logic [5:0]  RD_LEN_OUT,
    output logic [7:0]  RD_TYPE_OUT,
    output logic        NEW_OUT,
    output logic        IRQ_OUT,
    output logic [7:0]  DROP_CNT_OUT,
    output logic [7:0]  ERR_CNT_OUT
);

    localparam int          AW   = $clog2(2 * P_MAX_WORDS);
    localparam logic [5:0]  MAXW = 6'(P_MAX_WORDS);

    state_t      st_q, st_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  pkt_type_q, pkt_type_d;
    logic        bank_q, new_q, irq_q, rd_ok_q;
    logic [5:0]  len_q;
    logic [7:0]  type_q, drop_q, err_q;
    logic        we, commit, commit_ok, err_inc, type_ok, rd_in_range;
    logic [4:0]  wr_idx, rd_idx;
    logic [AW-1:0] wr_adr, rd_adr;
    logic [31:0] ram_dat;
    logic [7:0]  hb1;

    assign hb1     = hdr_hb1(SDP_DAT_IN);
    assign type_ok = (CFG_TYPE_IN == 8'h00) || (CFG_TYPE_IN == hb1);

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        pkt_type_d = pkt_type_q;
        we         = 1'b0;
        wr_idx     = cnt_q[4:0];
        commit     = 1'b0;
        err_inc    = 1'b0;
        if (!CFG_EN_IN) begin
            st_d = ST_IDLE;
        end else if (SDP_VLD_IN && SDP_SOP_IN) begin
            // a new SOP always restarts; only an interrupted capture is an error
            err_inc = (st_q == ST_CAP);
            if (type_ok) begin
                we         = 1'b1;
                wr_idx     = 5'd0;
                cnt_d      = 6'd1;
                pkt_type_d = hb1;
                commit     = SDP_EOP_IN;
                st_d       = SDP_EOP_IN ? ST_IDLE : ST_CAP;
            end else begin
                st_d = SDP_EOP_IN ? ST_IDLE : ST_DROP;
            end
        end else if (SDP_VLD_IN) begin
            case (st_q)
                ST_IDLE: err_inc = 1'b1;
                ST_CAP: begin
                    if (cnt_q >= MAXW) begin
                        err_inc = 1'b1;
                        st_d    = SDP_EOP_IN ? ST_IDLE : ST_DROP;
                    end else begin
                        we     = 1'b1;
                        cnt_d  = cnt_q + 6'd1;
                        commit = SDP_EOP_IN;
                        st_d   = SDP_EOP_IN ? ST_IDLE : ST_CAP;
                    end
                end
                default: st_d = SDP_EOP_IN ? ST_IDLE : ST_DROP;
            endcase
        end
    end

    // an ACK in the same cycle frees the host view for this commit
    assign commit_ok   = commit && !(new_q && !ACK_IN);
    assign rd_in_range = ({1'b0, RD_ADR_IN} < MAXW);
    assign rd_idx      = rd_in_range ? RD_ADR_IN : 5'd0;
    assign wr_adr      = AW'(bank_q ? {1'b0, wr_idx} : MAXW + {1'b0, wr_idx});
    assign rd_adr      = AW'(bank_q ? MAXW + {1'b0, rd_idx} : {1'b0, rd_idx});

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            st_q       <= ST_IDLE;
            cnt_q      <= '0;
            pkt_type_q <= '0;
            bank_q     <= 1'b0;
            new_q      <= 1'b0;
            irq_q      <= 1'b0;
            rd_ok_q    <= 1'b0;
            len_q      <= '0;
            type_q     <= '0;
            drop_q     <= '0;
            err_q      <= '0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            pkt_type_q <= pkt_type_d;
            irq_q      <= commit_ok;
            new_q      <= commit || (new_q && !ACK_IN);
            rd_ok_q    <= rd_in_range && ({1'b0, RD_ADR_IN} < len_q);
            if (commit_ok) begin
                bank_q <= ~bank_q;
                len_q  <= cnt_d;
                type_q <= pkt_type_d;
            end
            if (commit && !commit_ok && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    prt_dprx_sdp_ram #(
        .P_DEPTH(2 * P_MAX_WORDS),
        .P_AW   (AW)
    ) u_ram (
        .clk_i (CLK_IN),
        .we_i  (we),
        .wadr_i(wr_adr),
        .wdat_i(SDP_DAT_IN),
        .radr_i(rd_adr),
        .rdat_o(ram_dat)
    );

    assign RD_DAT_OUT   = rd_ok_q ? ram_dat : 32'h0;
    assign RD_LEN_OUT   = len_q;
    assign RD_TYPE_OUT  = type_q;
    assign NEW_OUT      = new_q;
    assign IRQ_OUT      = irq_q;
    assign DROP_CNT_OUT = drop_q;
    assign ERR_CNT_OUT  = err_q;

endmodule

// File: tb/tb_prt_dprx_sdp_cap.sv
// tb_prt_dprx_sdp_cap: directed scenarios for the SDP capture block.
module tb_prt_dprx_sdp_cap;

    logic        rst, clk, sop, eop, vld, en, ack;
    logic [31:0] dat, rd_dat;
    logic [7:0]  cfg_type, rd_type, drop_cnt, err_cnt;
    logic [4:0]  rd_adr;
    logic [5:0]  rd_len;
    logic        new_o, irq;
    int          errors = 0;
    int          checks = 0;

    prt_dprx_sdp_cap #(.P_MAX_WORDS(16)) dut (
        .RST_IN(rst), .CLK_IN(clk), .SDP_SOP_IN(sop), .SDP_EOP_IN(eop),
        .SDP_DAT_IN(dat), .SDP_VLD_IN(vld), .CFG_EN_IN(en), .CFG_TYPE_IN(cfg_type),
        .ACK_IN(ack), .RD_ADR_IN(rd_adr), .RD_DAT_OUT(rd_dat), .RD_LEN_OUT(rd_len),
        .RD_TYPE_OUT(rd_type), .NEW_OUT(new_o), .IRQ_OUT(irq),
        .DROP_CNT_OUT(drop_cnt), .ERR_CNT_OUT(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i, input logic [7:0] hb1, input logic [15:0] base);
        return (i == 0) ? {base[15:8], 8'hA5, hb1, 8'h5A} : {base, 16'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0; sop = 1'b0; eop = 1'b0; ack = 1'b0;
        en = 1'b1; cfg_type = 8'h00; rd_adr = 5'd0; dat = 32'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pkt(input int n, input logic [7:0] hb1, input logic [15:0] base,
                       input logic with_eop, input logic ack_last);
        for (int i = 0; i < n; i++) begin
            vld = 1'b1;
            sop = (i == 0);
            eop = with_eop && (i == n - 1);
            ack = ack_last && (i == n - 1);
            dat = word(i, hb1, base);
            tick();
        end
        vld = 1'b0; sop = 1'b0; eop = 1'b0; ack = 1'b0;
    endtask

    task automatic host_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({new_o, irq, rd_len, rd_type, drop_cnt, err_cnt, rd_dat} !== 64'h0) begin
            errors++;
            $display("FAIL reset: new=%b irq=%b len=%0d type=%h drop=%0d err=%0d dat=%h required all 0",
                     new_o, irq, rd_len, rd_type, drop_cnt, err_cnt, rd_dat);
        end
    endtask

    task automatic test_basic();
        do_reset();
        pkt(9, 8'h84, 16'h1000, 1'b1, 1'b0);
        checks++;
        if ({irq, new_o, rd_len, rd_type} !== {1'b1, 1'b1, 6'd9, 8'h84}) begin
            errors++;
            $display("FAIL basic_commit: irq=%b new=%b len=%0d type=%h required 1 1 9 84", irq, new_o, rd_len, rd_type);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_pulse: irq=%b required 0", irq);
        end
        for (int i = 0; i < 11; i++) begin
            rd_adr = (i == 10) ? 5'd20 : 5'(i);
            tick();
            checks++;
            if (rd_dat !== ((i < 9) ? word(i, 8'h84, 16'h1000) : 32'h0)) begin
                errors++;
                $display("FAIL basic_read[%0d]: got %h required %h", rd_adr, rd_dat,
                         (i < 9) ? word(i, 8'h84, 16'h1000) : 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        pkt(4, 8'h11, 16'h2000, 1'b1, 1'b0);
        checks++;
        if ({irq, new_o, drop_cnt, rd_len, rd_type} !== {1'b0, 1'b1, 8'd1, 6'd9, 8'h84}) begin
            errors++;
            $display("FAIL b2b_drop: irq=%b new=%b drop=%0d len=%0d type=%h required 0 1 1 9 84",
                     irq, new_o, drop_cnt, rd_len, rd_type);
        end
        rd_adr = 5'd3;
        tick();
        checks++;
        if (rd_dat !== word(3, 8'h84, 16'h1000)) begin
            errors++;
            $display("FAIL b2b_data: got %h required %h", rd_dat, word(3, 8'h84, 16'h1000));
        end
        host_ack();
        checks++;
        if (new_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: new=%b required 0", new_o);
        end
        pkt(3, 8'h22, 16'h3000, 1'b1, 1'b0);
        rd_adr = 5'd2;
        checks++;
        if ({irq, new_o, rd_len, rd_type, drop_cnt} !== {1'b1, 1'b1, 6'd3, 8'h22, 8'd1}) begin
            errors++;
            $display("FAIL third_commit: irq=%b new=%b len=%0d type=%h drop=%0d required 1 1 3 22 1",
                     irq, new_o, rd_len, rd_type, drop_cnt);
        end
        tick();
        checks++;
        if (rd_dat !== word(2, 8'h22, 16'h3000)) begin
            errors++;
            $display("FAIL third_data: got %h required %h", rd_dat, word(2, 8'h22, 16'h3000));
        end
    endtask

    task automatic test_filter();
        do_reset();
        cfg_type = 8'h87;
        pkt(5, 8'h84, 16'h4000, 1'b1, 1'b0);
        checks++;
        if ({irq, new_o, drop_cnt, err_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL filter_reject: irq=%b new=%b drop=%0d err=%0d required 0 0 0 0", irq, new_o, drop_cnt, err_cnt);
        end
        pkt(3, 8'h87, 16'h4100, 1'b1, 1'b0);
        checks++;
        if ({irq, new_o, rd_len, rd_type} !== {1'b1, 1'b1, 6'd3, 8'h87}) begin
            errors++;
            $display("FAIL filter_accept: irq=%b new=%b len=%0d type=%h required 1 1 3 87", irq, new_o, rd_len, rd_type);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        pkt(17, 8'h05, 16'h5000, 1'b1, 1'b0);
        checks++;
        if ({irq, new_o, err_cnt, drop_cnt} !== {1'b0, 1'b0, 8'd1, 8'd0}) begin
            errors++;
            $display("FAIL overflow: irq=%b new=%b err=%0d drop=%0d required 0 0 1 0", irq, new_o, err_cnt, drop_cnt);
        end
        pkt(4, 8'h06, 16'h5100, 1'b1, 1'b0);
        checks++;
        if ({new_o, rd_len, rd_type, err_cnt} !== {1'b1, 6'd4, 8'h06, 8'd1}) begin
            errors++;
            $display("FAIL after_overflow: new=%b len=%0d type=%h err=%0d required 1 4 06 1", new_o, rd_len, rd_type, err_cnt);
        end
    endtask

    task automatic test_abort();
        do_reset();
        pkt(3, 8'h31, 16'h6000, 1'b0, 1'b0);
        tick();
        pkt(5, 8'h32, 16'h6100, 1'b1, 1'b0);
        checks++;
        if ({new_o, rd_len, rd_type, err_cnt} !== {1'b1, 6'd5, 8'h32, 8'd1}) begin
            errors++;
            $display("FAIL abort: new=%b len=%0d type=%h err=%0d required 1 5 32 1", new_o, rd_len, rd_type, err_cnt);
        end
        host_ack();
        pkt(1, 8'h33, 16'h6200, 1'b1, 1'b0);
        rd_adr = 5'd0;
        checks++;
        if ({irq, new_o, rd_len, rd_type} !== {1'b1, 1'b1, 6'd1, 8'h33}) begin
            errors++;
            $display("FAIL single_beat: irq=%b new=%b len=%0d type=%h required 1 1 1 33", irq, new_o, rd_len, rd_type);
        end
        tick();
        checks++;
        if (rd_dat !== word(0, 8'h33, 16'h6200)) begin
            errors++;
            $display("FAIL single_data: got %h required %h", rd_dat, word(0, 8'h33, 16'h6200));
        end
        vld = 1'b1; dat = 32'hDEAD_BEEF;
        tick();
        vld = 1'b0;
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL idle_no_sop: err=%0d required 2", err_cnt);
        end
    endtask

    task automatic test_ack_coincide();
        do_reset();
        pkt(2, 8'h41, 16'h7000, 1'b1, 1'b0);
        pkt(6, 8'h42, 16'h7100, 1'b1, 1'b1);
        checks++;
        if ({irq, new_o, rd_len, rd_type, drop_cnt} !== {1'b1, 1'b1, 6'd6, 8'h42, 8'd0}) begin
            errors++;
            $display("FAIL ack_coincide: irq=%b new=%b len=%0d type=%h drop=%0d required 1 1 6 42 0",
                     irq, new_o, rd_len, rd_type, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        pkt(3, 8'h51, 16'h8000, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({new_o, irq, rd_len, rd_type, drop_cnt, err_cnt, rd_dat} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid: new=%b irq=%b len=%0d type=%h drop=%0d err=%0d dat=%h required all 0",
                     new_o, irq, rd_len, rd_type, drop_cnt, err_cnt, rd_dat);
        end
        pkt(1, 8'h52, 16'h8100, 1'b1, 1'b0);
        checks++;
        if ({new_o, rd_len, err_cnt} !== {1'b1, 6'd1, 8'd0}) begin
            errors++;
            $display("FAIL after_reset_mid: new=%b len=%0d err=%0d required 1 1 0", new_o, rd_len, err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; sop = 1'b0; eop = 1'b0; ack = 1'b0;
        en = 1'b1; cfg_type = 8'h00; rd_adr = 5'd0; dat = 32'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_filter();
        test_overflow();
        test_abort();
        test_ack_coincide();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
